irq_controller: RTL and testbench

- Parametrised multi-source interrupt controller; successor to the single-source, single-vector keyboard interrupt latch in the board top level.
- Latches N_SRC sources, each individually configurable as edge or level. Arbitrates with fixed priority or round-robin and presents one vector to riscv64 over the interrupt_vector / interrupt_ack handshake.
- Exposes enable, mode, pending, arbitration and claim registers on the system bus.
- Sits between peripherals (PS/2 decoder, UART, timer) and the CPU, in the bus controller's address map.

---
 rtl/irq_controller.sv | 204 ++++++++++++++++++++
 tb/tb_irq_controller.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Multi-source interrupt controller: per-source edge/level latching, fixed or
// round-robin arbitration, one vector at a time over the vector/ack handshake.
module irq_controller #(
    parameter int N_SRC  = 8,
    parameter int VEC_W  = 4,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SRC-1:0]  src,
    output logic [VEC_W-1:0]  interrupt_vector,
    input  logic              interrupt_ack,
    input  logic [ADDR_W-1:0] bus_address,
    input  logic              bus_write_enable,
    input  logic [31:0]       bus_write_data,
    input  logic              bus_read_enable,
    output logic [31:0]       bus_read_data,
    output logic [N_SRC-1:0]  irq_pending
);

    localparam int WORD_W = ADDR_W - 2;

    localparam logic [WORD_W-1:0] OFS_ENABLE  = WORD_W'(0);
    localparam logic [WORD_W-1:0] OFS_MODE    = WORD_W'(1);
    localparam logic [WORD_W-1:0] OFS_PENDING = WORD_W'(2);
    localparam logic [WORD_W-1:0] OFS_ARB     = WORD_W'(3);
    localparam logic [WORD_W-1:0] OFS_CLAIM   = WORD_W'(4);

    if (N_SRC < 1 || N_SRC > 31 || (2 ** VEC_W) <= N_SRC) begin : g_param_check
        $error("irq_controller: N_SRC must be 1..31 and fit in VEC_W with vector 0 reserved");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        WAIT_REL
    } state_t;

    state_t             state;
    logic [VEC_W-1:0]   sel;
    logic [VEC_W-1:0]   rr_ptr;

    logic [N_SRC-1:0]   enable_r;
    logic [N_SRC-1:0]   mode_r;
    logic [N_SRC-1:0]   pending_r;
    logic               arb_rr;
    logic [N_SRC-1:0]   src_q;

    logic [WORD_W-1:0]  word;
    logic [N_SRC-1:0]   wdata;
    logic [N_SRC-1:0]   w1c;
    logic [N_SRC-1:0]   ack_clr;
    logic [N_SRC-1:0]   edge_next;
    logic [N_SRC-1:0]   eligible;

    logic [VEC_W-1:0]   low_idx;
    logic [VEC_W-1:0]   above_idx;
    logic               above_found;
    logic [VEC_W-1:0]   winner;

    logic [31:0]        read_value;
    logic               unused_bits;

    assign word        = bus_address[ADDR_W-1:2];
    assign wdata       = bus_write_data[N_SRC-1:0];
    assign unused_bits = ^{bus_address[1:0], bus_write_data};
    assign irq_pending = pending_r;
    assign eligible    = pending_r & enable_r;

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            enable_r <= '0;
            mode_r   <= '0;
            arb_rr   <= 1'b0;
        end else if (bus_write_enable) begin
            case (word)
                OFS_ENABLE: enable_r <= wdata;
                OFS_MODE:   mode_r   <= wdata;
                OFS_ARB:    arb_rr   <= bus_write_data[0];
                default:    ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pending latch
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (state == PRESENT && interrupt_ack && sel == VEC_W'(i)) begin
                ack_clr[i] = 1'b1;
            end
        end
    end

    assign w1c = (bus_write_enable && word == OFS_PENDING) ? wdata : '0;

    // The rising-edge term is OR'ed in last, so a new edge beats a same-cycle clear.
    assign edge_next = (pending_r & ~(w1c | ack_clr)) | (src & ~src_q);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_r <= '0;
            src_q     <= '0;
        end else begin
            pending_r <= (mode_r & edge_next) | (~mode_r & src);
            src_q     <= src;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // Round-robin prefers the lowest eligible index above rr_ptr and falls
    // back to the lowest overall, which is the wrap-around search.
    always_comb begin
        low_idx     = '0;
        above_idx   = '0;
        above_found = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                low_idx = VEC_W'(i);
                if (VEC_W'(i) > rr_ptr) begin
                    above_idx   = VEC_W'(i);
                    above_found = 1'b1;
                end
            end
        end
        winner = (arb_rr && above_found) ? above_idx : low_idx;
    end

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            sel              <= '0;
            rr_ptr           <= VEC_W'(N_SRC - 1);
            interrupt_vector <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        sel              <= winner;
                        interrupt_vector <= winner + VEC_W'(1);
                        state            <= PRESENT;
                    end else begin
                        interrupt_vector <= '0;
                    end
                end
                PRESENT: begin
                    if (interrupt_ack) begin
                        interrupt_vector <= '0;
                        rr_ptr           <= sel;
                        state            <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    interrupt_vector <= '0;
                    if (!interrupt_ack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    interrupt_vector <= '0;
                    state            <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register read port
    // ------------------------------------------------------------------
    always_comb begin
        read_value = '0;
        case (word)
            OFS_ENABLE:  read_value = 32'(enable_r);
            OFS_MODE:    read_value = 32'(mode_r);
            OFS_PENDING: read_value = 32'(pending_r);
            OFS_ARB:     read_value = {31'd0, arb_rr};
            OFS_CLAIM:   if (state == PRESENT) read_value = 32'(sel) + 32'd1;
            default:     ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus_read_data <= '0;
        end else if (bus_read_enable) begin
            bus_read_data <= read_value;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus randomized
// traffic, all compared each cycle against a behavioural model.
module tb_irq_controller;

    localparam int N_SRC  = 8;
    localparam int VEC_W  = 4;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [N_SRC-1:0]  src;
    logic [VEC_W-1:0]  interrupt_vector;
    logic              interrupt_ack;
    logic [ADDR_W-1:0] bus_address;
    logic              bus_write_enable;
    logic [31:0]       bus_write_data;
    logic              bus_read_enable;
    logic [31:0]       bus_read_data;
    logic [N_SRC-1:0]  irq_pending;

    always #5 clk = ~clk;

    irq_controller #(.N_SRC(N_SRC), .VEC_W(VEC_W), .ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .src              (src),
        .interrupt_vector (interrupt_vector),
        .interrupt_ack    (interrupt_ack),
        .bus_address      (bus_address),
        .bus_write_enable (bus_write_enable),
        .bus_write_data   (bus_write_data),
        .bus_read_enable  (bus_read_enable),
        .bus_read_data    (bus_read_data),
        .irq_pending      (irq_pending)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: the presented vector doubles as the claim value,
    // and a separate flag marks "waiting for ack release".
    logic [7:0]  m_en, m_mode, m_pend, m_srcq;
    bit          m_arb;
    int          m_vec;
    bit          m_wait;
    int          m_last;
    logic [31:0] m_rd;
    int          claim_log[$];

    function automatic int pick(input logic [7:0] elig, input bit rr, input int last);
        int         start;
        logic [2:0] idx;
        start = rr ? (last + 1) % N_SRC : 0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = 3'((start + k) % N_SRC);
            if (elig[idx]) return int'(idx);
        end
        return -1;
    endfunction

    function automatic logic [31:0] reg_read(input logic [4:0] a);
        case (a[4:2])
            3'd0:    return 32'(m_en);
            3'd1:    return 32'(m_mode);
            3'd2:    return 32'(m_pend);
            3'd3:    return {31'd0, m_arb};
            3'd4:    return 32'(m_vec);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic [7:0] elig, rise, clr, old_pend;
        int         g;
        if (!reset) begin
            m_en = 0; m_mode = 0; m_pend = 0; m_srcq = 0; m_arb = 0;
            m_vec = 0; m_wait = 0; m_last = N_SRC - 1; m_rd = 0;
            return;
        end
        old_pend = m_pend;
        elig     = m_pend & m_en;
        rise     = src & ~m_srcq;
        clr      = 8'd0;
        if (bus_read_enable) m_rd = reg_read(bus_address);
        if (m_vec != 0) begin
            if (interrupt_ack) begin
                g      = m_vec - 1;
                clr    = clr | (8'd1 << g);
                m_last = g;
                m_vec  = 0;
                m_wait = 1;
            end
        end else if (m_wait) begin
            if (!interrupt_ack) m_wait = 0;
        end else begin
            g = pick(elig, m_arb, m_last);
            if (g >= 0) m_vec = g + 1;
        end
        if (bus_write_enable && bus_address[4:2] == 3'd2) clr = clr | bus_write_data[7:0];
        m_pend = (m_mode & ((old_pend & ~clr) | rise)) | (~m_mode & src);
        m_srcq = src;
        if (bus_write_enable) begin
            case (bus_address[4:2])
                3'd0:    m_en   = bus_write_data[7:0];
                3'd1:    m_mode = bus_write_data[7:0];
                3'd3:    m_arb  = bus_write_data[0];
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("vector", 32'(interrupt_vector), 32'(m_vec));
        check("pending", 32'(irq_pending), 32'(m_pend));
        check("rdata", bus_read_data, m_rd);
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        bus_address      = a;
        bus_write_data   = d;
        bus_write_enable = 1'b1;
        tick();
        bus_write_enable = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus_address     = a;
        bus_read_enable = 1'b1;
        tick();
        bus_read_enable = 1'b0;
        check(tag, bus_read_data, exp);
    endtask

    // Wait for a vector, optionally read CLAIM, ack it, optionally re-pulse sources.
    task automatic serve_one(input bit claim_rd, input logic [31:0] claim_exp,
                             input bit repulse, input logic [7:0] mask);
        int n = 0;
        while (interrupt_vector == 0 && n < 20) begin
            tick();
            n++;
        end
        check("present_in_time", 32'(n < 20), 32'd1);
        if (claim_rd) rd_check("claim", 5'h10, claim_exp);
        claim_log.push_back(int'(interrupt_vector));
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        if (repulse) begin
            src = mask;
            tick();
            src = 8'h00;
        end
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; src = 8'hFF; interrupt_ack = 1'b0;
        bus_address = '0; bus_write_enable = 1'b0; bus_write_data = '0; bus_read_enable = 1'b0;

        // Reset
        tick();
        tick();
        check("rst_vector", 32'(interrupt_vector), 32'd0);
        check("rst_pending", 32'(irq_pending), 32'd0);
        src   = 8'h00;
        reset = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) rd_check("rst_reg", 5'(a * 4), 32'd0);

        // Single edge source, held ack
        bus_wr(5'h00, 32'h08);
        bus_wr(5'h04, 32'hFF);
        src = 8'h08;
        tick();
        src = 8'h00;
        check("edge_pend", 32'(irq_pending), 32'h08);
        tick();
        check("edge_vec", 32'(interrupt_vector), 32'd4);
        interrupt_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_ack_vec", 32'(interrupt_vector), 32'd0);
            check("held_ack_pend", 32'(irq_pending), 32'd0);
        end
        interrupt_ack = 1'b0;
        repeat (3) tick();
        check("single_claim", 32'(interrupt_vector), 32'd0);

        // Fixed priority
        bus_wr(5'h00, 32'hFF);
        src = 8'h24;
        tick();
        src = 8'h00;
        claim_log.delete();
        serve_one(1'b1, 32'd3, 1'b0, 8'h00);
        serve_one(1'b0, 32'd0, 1'b0, 8'h00);
        check("fixed_cnt", 32'(claim_log.size()), 32'd2);
        check("fixed_first", 32'(claim_log[0]), 32'd3);
        check("fixed_second", 32'(claim_log[1]), 32'd6);

        // Round-robin, then fixed with the same traffic
        bus_wr(5'h0C, 32'h1);
        src = 8'h03;
        tick();
        src = 8'h00;
        claim_log.delete();
        repeat (4) serve_one(1'b0, 32'd0, 1'b1, 8'h03);
        check("rr_cnt", 32'(claim_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("rr_seq", 32'(claim_log[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
        claim_log.delete();
        bus_wr(5'h0C, 32'h0);
        repeat (3) serve_one(1'b0, 32'd0, 1'b1, 8'h03);
        check("fixed_cnt3", 32'(claim_log.size()), 32'd3);
        for (int i = 0; i < 3; i++) check("fixed_seq", 32'(claim_log[i]), 32'd1);
        serve_one(1'b0, 32'd0, 1'b0, 8'h00);
        serve_one(1'b0, 32'd0, 1'b0, 8'h00);
        check("drain_last", 32'(claim_log[4]), 32'd2);

        // Level source held across ack
        bus_wr(5'h04, 32'h00);
        bus_wr(5'h00, 32'h01);
        src = 8'h01;
        tick();
        tick();
        check("level_vec", 32'(interrupt_vector), 32'd1);
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        tick();
        check("level_gap", 32'(interrupt_vector), 32'd0);
        tick();
        check("level_represent", 32'(interrupt_vector), 32'd1);
        interrupt_ack = 1'b1;
        src = 8'h00;
        tick();
        interrupt_ack = 1'b0;
        repeat (3) tick();
        check("level_drop_pend", 32'(irq_pending[0]), 32'd0);
        check("level_drop_vec", 32'(interrupt_vector), 32'd0);

        // W1C colliding with a new edge, then plain W1C
        bus_wr(5'h00, 32'h00);
        bus_wr(5'h04, 32'hFF);
        src = 8'h02;
        tick();
        src = 8'h00;
        tick();
        src = 8'h02;
        bus_wr(5'h08, 32'h02);
        src = 8'h00;
        check("w1c_collide", 32'(irq_pending[1]), 32'd1);
        bus_wr(5'h08, 32'h02);
        check("w1c_clear", 32'(irq_pending[1]), 32'd0);

        // Masked source, then enabled
        src = 8'h10;
        tick();
        src = 8'h00;
        repeat (3) tick();
        check("masked_vec", 32'(interrupt_vector), 32'd0);
        bus_wr(5'h00, 32'h10);
        check("unmask_wait", 32'(interrupt_vector), 32'd0);
        tick();
        check("unmask_vec", 32'(interrupt_vector), 32'd5);
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        tick();

        // Randomized traffic, including occasional mid-handshake resets
        for (int n = 0; n < 3000; n++) begin
            reset            = ($urandom_range(0, 199) != 0);
            src              = src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            interrupt_ack    = ($urandom_range(0, 3) == 0);
            bus_write_enable = ($urandom_range(0, 7) == 0);
            bus_read_enable  = ($urandom_range(0, 2) == 0);
            bus_address      = 5'($urandom);
            bus_write_data   = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
